// File: rtl/register_file_dump.sv
// register_file_dump: DEPTH x WIDTH register file for the fdt16 datapath.
// It has one synchronous write port, two combinational read ports with a
// write bypass, and a dump engine that streams every register out in
// ascending order over a valid/ready handshake.
//
// Ports:
//   clk, reset                  rising-edge clock, async active-low reset
//   we, waddr, wdata            write port
//   raddr_a/rdata_a             read port A (combinational, write-bypassed)
//   raddr_b/rdata_b             read port B (combinational, write-bypassed)
//   dump_start                  request a full dump (honoured only in IDLE)
//   dump_busy                   engine is not IDLE
//   dump_valid/ready            stream handshake
//   dump_addr/dump_data         entry being presented
//   dump_done                   one-cycle pulse after the last entry is taken
module register_file_dump #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WIDTH-1:0]  rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_b,
    input  logic              dump_start,
    output logic              dump_busy,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [WIDTH-1:0]  dump_data,
    output logic              dump_done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    logic [WIDTH-1:0]  regs_q [DEPTH];

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0]  hold_q, hold_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;

    logic [ADDR_W-1:0] load_addr;
    logic [WIDTH-1:0]  load_val;

    // Register array: cleared on reset, one write per cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs_q[i] <= '0;
            end
        end else if (we) begin
            regs_q[waddr] <= wdata;
        end
    end

    // Read ports forward a same-cycle write to the addressed register.
    assign rdata_a = (we && (waddr == raddr_a)) ? wdata : regs_q[raddr_a];
    assign rdata_b = (we && (waddr == raddr_b)) ? wdata : regs_q[raddr_b];

    // Entry that would be captured into hold this cycle: register 0 when a
    // dump starts, otherwise the one after the entry being presented.
    assign load_addr = (state_q == ST_IDLE) ? '0 : (idx_q + ADDR_W'(1));
    assign load_val  = (we && (waddr == load_addr)) ? wdata : regs_q[load_addr];

    // Dump engine state and registered stream outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            hold_q  <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; status flags are derived from the next state so the
    // outputs come straight from flops.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;

        unique case (state_q)
            ST_IDLE: begin
                if (dump_start) begin
                    state_d = ST_SEND;
                    idx_d   = '0;
                    hold_d  = load_val;
                end
            end
            ST_SEND: begin
                if (valid_q && dump_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d  = load_addr;
                        hold_d = load_val;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d  = (state_d != ST_IDLE);
        valid_d = (state_d == ST_SEND);
        done_d  = (state_d == ST_DONE);
    end

    assign dump_busy  = busy_q;
    assign dump_valid = valid_q;
    assign dump_done  = done_q;
    assign dump_addr  = idx_q;
    assign dump_data  = hold_q;

endmodule

// File: tb/tb_register_file_dump.sv
// Testbench for register_file_dump: table-driven read/write vectors plus
// hand-written dump sequences (free-running, backpressure, writes during a
// dump, start while busy, reset mid-dump).
module tb_register_file_dump;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned ADDR_W = 3;

    logic              clk;
    logic              reset;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [WIDTH-1:0]  wdata;
    logic [ADDR_W-1:0] raddr_a;
    logic [WIDTH-1:0]  rdata_a;
    logic [ADDR_W-1:0] raddr_b;
    logic [WIDTH-1:0]  rdata_b;
    logic              dump_start;
    logic              dump_busy;
    logic              dump_valid;
    logic              dump_ready;
    logic [ADDR_W-1:0] dump_addr;
    logic [WIDTH-1:0]  dump_data;
    logic              dump_done;

    register_file_dump #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .raddr_a   (raddr_a),
        .rdata_a   (rdata_a),
        .raddr_b   (raddr_b),
        .rdata_b   (rdata_b),
        .dump_start(dump_start),
        .dump_busy (dump_busy),
        .dump_valid(dump_valid),
        .dump_ready(dump_ready),
        .dump_addr (dump_addr),
        .dump_data (dump_data),
        .dump_done (dump_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] waddr;
        logic [WIDTH-1:0]  wdata;
        logic [ADDR_W-1:0] ra;
        logic [ADDR_W-1:0] rb;
        logic [WIDTH-1:0]  exp_a;
        logic [WIDTH-1:0]  exp_b;
    } rw_vec_t;

    rw_vec_t          vecs [8];
    logic [WIDTH-1:0] exp_data [DEPTH];
    logic [ADDR_W-1:0] got_a [16];
    logic [WIDTH-1:0]  got_d [16];

    int n_pass;
    int n_total;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_regs();
        for (int i = 0; i < int'(DEPTH); i++) begin
            we    = 1'b1;
            waddr = ADDR_W'(i);
            wdata = 16'h1000 + 16'(i);
            tick();
        end
        we = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) exp_data[i] = 16'h1000 + 16'(i);
    endtask

    // mode 0: ready tied high; 1: ready 1,0,0 repeating;
    // 2: stall on entry 2 and write r2/r6; 3: start pulsed in SEND and DONE.
    task automatic run_dump(input int mode);
        int   n;
        int   done_cnt;
        int   first_c;
        int   last_c;
        int   done_c;
        int   stall;
        int   c;
        logic r;
        logic prev_stall;
        logic [ADDR_W-1:0] prev_a;
        logic [WIDTH-1:0]  prev_d;
        n = 0; done_cnt = 0; first_c = -1; last_c = -1; done_c = -100; stall = 0;
        prev_stall = 1'b0; prev_a = '0; prev_d = '0;

        dump_start = 1'b1;
        dump_ready = 1'b0;
        tick();
        dump_start = 1'b0;
        check($sformatf("m%0d_valid_after_start", mode), 32'(dump_valid), 32'd1);
        check($sformatf("m%0d_busy_after_start", mode), 32'(dump_busy), 32'd1);

        c = 0;
        while (dump_busy && c < 100) begin
            r          = 1'b1;
            we         = 1'b0;
            dump_start = 1'b0;
            case (mode)
                1: r = ((c % 3) == 0);
                2: begin
                    if (dump_valid && dump_addr == 3'd2) begin
                        if (stall == 0) begin
                            r = 1'b0; we = 1'b1; waddr = 3'd2; wdata = 16'hBEEF;
                        end else if (stall == 1) begin
                            r = 1'b0; we = 1'b1; waddr = 3'd6; wdata = 16'hCAFE;
                        end
                        stall++;
                    end
                end
                3: dump_start = (c == 3) || dump_done;
                default: r = 1'b1;
            endcase

            if (prev_stall) begin
                check($sformatf("m%0d_hold_addr_c%0d", mode, c), 32'(dump_addr), 32'(prev_a));
                check($sformatf("m%0d_hold_data_c%0d", mode, c), 32'(dump_data), 32'(prev_d));
            end
            if (dump_valid && r) begin
                if (n < 16) begin
                    got_a[n] = dump_addr;
                    got_d[n] = dump_data;
                end
                if (n == 0) first_c = c;
                last_c = c;
                n++;
            end
            if (dump_done) begin
                done_cnt++;
                done_c = c;
                check($sformatf("m%0d_valid_low_in_done", mode), 32'(dump_valid), 32'd0);
            end
            prev_stall = dump_valid && !r;
            prev_a     = dump_addr;
            prev_d     = dump_data;
            dump_ready = r;
            tick();
            c++;
        end
        dump_start = 1'b0;
        dump_ready = 1'b0;
        we         = 1'b0;

        check($sformatf("m%0d_finished_in_budget", mode), 32'(dump_busy), 32'd0);
        check($sformatf("m%0d_entry_count", mode), 32'(n), 32'd8);
        check($sformatf("m%0d_done_pulses", mode), 32'(done_cnt), 32'd1);
        check($sformatf("m%0d_done_timing", mode), 32'(done_c), 32'(last_c + 1));
        if (mode == 0) begin
            check("m0_back_to_back", 32'(last_c - first_c), 32'd7);
        end
        for (int i = 0; i < int'(DEPTH) && i < n; i++) begin
            check($sformatf("m%0d_entry%0d_addr", mode, i), 32'(got_a[i]), 32'(i));
            check($sformatf("m%0d_entry%0d_data", mode, i), 32'(got_d[i]), 32'(exp_data[i]));
        end
        tick();
        check($sformatf("m%0d_idle_after", mode), 32'(dump_busy), 32'd0);
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;

        //          we    waddr wdata     ra    rb    exp_a     exp_b
        vecs[0] = '{1'b1, 3'd3, 16'hAAAA, 3'd3, 3'd5, 16'hAAAA, 16'h0000};
        vecs[1] = '{1'b1, 3'd5, 16'hF0F0, 3'd3, 3'd5, 16'hAAAA, 16'hF0F0};
        vecs[2] = '{1'b0, 3'd0, 16'h0000, 3'd3, 3'd5, 16'hAAAA, 16'hF0F0};
        vecs[3] = '{1'b1, 3'd3, 16'h5555, 3'd3, 3'd3, 16'h5555, 16'h5555};
        vecs[4] = '{1'b0, 3'd3, 16'h1111, 3'd3, 3'd5, 16'h5555, 16'hF0F0};
        vecs[5] = '{1'b1, 3'd0, 16'h1234, 3'd7, 3'd0, 16'h0000, 16'h1234};
        vecs[6] = '{1'b1, 3'd7, 16'hFFFF, 3'd7, 3'd0, 16'hFFFF, 16'h1234};
        vecs[7] = '{1'b0, 3'd0, 16'h0000, 3'd0, 3'd7, 16'h1234, 16'hFFFF};

        reset = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
        raddr_a = 3'd3; raddr_b = 3'd7;
        dump_start = 1'b0; dump_ready = 1'b0;

        // Reset state
        #12;
        check("rst_rdata_a", 32'(rdata_a), 32'd0);
        check("rst_rdata_b", 32'(rdata_b), 32'd0);
        check("rst_valid", 32'(dump_valid), 32'd0);
        check("rst_busy", 32'(dump_busy), 32'd0);
        check("rst_done", 32'(dump_done), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("post_rst_busy", 32'(dump_busy), 32'd0);

        // Read/write vectors with bypass
        for (int i = 0; i < 8; i++) begin
            we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
            raddr_a = vecs[i].ra; raddr_b = vecs[i].rb;
            #1;
            check($sformatf("rw%0d_a", i), 32'(rdata_a), 32'(vecs[i].exp_a));
            check($sformatf("rw%0d_b", i), 32'(rdata_b), 32'(vecs[i].exp_b));
            tick();
        end
        we = 1'b0;

        // Dump, ready tied high
        load_regs();
        run_dump(0);

        // Dump with backpressure
        run_dump(1);

        // Writes during a stalled entry
        exp_data[6] = 16'hCAFE;
        run_dump(2);
        raddr_a = 3'd2; raddr_b = 3'd6;
        #1;
        check("after_wr_r2", 32'(rdata_a), 32'hBEEF);
        check("after_wr_r6", 32'(rdata_b), 32'hCAFE);

        // Start pulsed while busy
        load_regs();
        run_dump(3);

        // Reset mid-dump
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        dump_ready = 1'b1;
        tick();
        tick();
        dump_ready = 1'b0;
        check("mid_pre_valid", 32'(dump_valid), 32'd1);
        check("mid_pre_addr", 32'(dump_addr), 32'd2);
        #2;
        reset = 1'b0;
        raddr_a = 3'd5;
        #1;
        check("mid_rst_valid", 32'(dump_valid), 32'd0);
        check("mid_rst_busy", 32'(dump_busy), 32'd0);
        check("mid_rst_addr", 32'(dump_addr), 32'd0);
        check("mid_rst_data", 32'(dump_data), 32'd0);
        check("mid_rst_rdata", 32'(rdata_a), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        tick();
        check("mid_rst_stays_idle", 32'(dump_busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
